// File: rtl/fg_config_writer.sv
// Serializes a masked 64-bit configuration word into strobed 8-bit register writes
// for the function generator's synchronized register port.
//
// state  | meaning
// IDLE   | waiting for start_i; latches cfg/mask on start
// SETUP  | addr/data presented, strobe low
// STROBE | write enable held high for the receiver synchronizer
// GAP    | strobe low, addr/data still held; then next register or DONE
// DONE   | one-cycle done pulse, then back to IDLE
module fg_config_writer #(
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [63:0] cfg_i,
  input  logic [7:0]  mask_i,
  output logic [7:0]  data_o,
  output logic [2:0]  addr_o,
  output logic        wr_en_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int MAXC0 = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAXC  = (MAXC0 > GAP_CYCLES) ? MAXC0 : GAP_CYCLES;
  localparam int CW    = (MAXC <= 1) ? 1 : $clog2(MAXC);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   cfg_q, cfg_d;
  logic [7:0]    mask_q, mask_d;
  logic [7:0]    data_q, data_d;
  logic [2:0]    addr_q, addr_d;
  logic          wr_en_q, busy_q, done_q;
  logic [3:0]    nx_first, nx_after;

  // {found, index} of the lowest set mask bit at or above lo
  function automatic logic [3:0] next_set(input logic [7:0] m, input logic [3:0] lo);
    logic [3:0] r;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k] && (k >= int'(lo))) r = {1'b1, 3'(k)};
    end
    return r;
  endfunction

  function automatic logic [7:0] byte_of(input logic [63:0] c, input logic [2:0] a);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      if (a == 3'(k)) b = c[63-8*k -: 8];
    end
    return b;
  endfunction

  assign nx_first = next_set(mask_i, 4'd0);
  assign nx_after = next_set(mask_q, {1'b0, addr_q} + 4'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    mask_d  = mask_q;
    data_d  = data_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cfg_d  = cfg_i;
          mask_d = mask_i;
          if (nx_first[3]) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
            addr_d  = nx_first[2:0];
            data_d  = byte_of(cfg_i, nx_first[2:0]);
          end else begin
            // empty mask: one quiet busy cycle before the done pulse
            state_d = S_GAP;
            cnt_d   = '0;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (nx_after[3] && (mask_q != 8'h00)) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          addr_d  = nx_after[2:0];
          data_d  = byte_of(cfg_q, nx_after[2:0]);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wr_en_q <= (state_d == S_STROBE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign wr_en_o = wr_en_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_fg_config_writer.sv
// Directed bench for fg_config_writer: default-timing instance plus a
// SETUP=2/HOLD=3/GAP=3 instance, checked against hand-computed cycle counts.
module tb_fg_config_writer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] cfg;
  logic [7:0]  mask;
  logic [7:0]  data;
  logic [2:0]  addr;
  logic        wr_en, busy, done;

  logic        rst_b, start_b;
  logic [63:0] cfg_b;
  logic [7:0]  mask_b;
  logic [7:0]  data_b;
  logic [2:0]  addr_b;
  logic        wr_en_b, busy_b, done_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fg_config_writer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_i(cfg), .mask_i(mask),
    .data_o(data), .addr_o(addr), .wr_en_o(wr_en), .busy_o(busy), .done_o(done)
  );

  fg_config_writer #(.SETUP_CYCLES(2), .HOLD_CYCLES(3), .GAP_CYCLES(3)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .cfg_i(cfg_b), .mask_i(mask_b),
    .data_o(data_b), .addr_o(addr_b), .wr_en_o(wr_en_b), .busy_o(busy_b), .done_o(done_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one transfer on the default instance; cycle k = k edges after the start edge.
  // hold_start keeps start_i high and swaps cfg_i mid-transfer.
  task automatic xfer(input string tag, input logic [63:0] c, input logic [7:0] m,
                      input int exp_done, input bit hold_start);
    int   rise_at[8];
    logic [2:0] ad[8];
    logic [7:0] dt[8];
    int   nrise, high_cnt, done_at, done_cnt, viol, since_fall, n_exp;
    logic prev_wr, busy_after, busy_first;
    logic [2:0] paddr;
    logic [7:0] pdata;
    logic [2:0] exp_addr[8];

    n_exp = 0;
    for (int i = 0; i < 8; i++) begin
      exp_addr[i] = '0;
      if (m[i]) begin
        exp_addr[n_exp] = 3'(i);
        n_exp++;
      end
    end

    @(negedge clk);
    cfg = c; mask = m; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    nrise = 0; high_cnt = 0; done_at = -1; done_cnt = 0; viol = 0;
    since_fall = 100; prev_wr = 1'b0; busy_after = 1'b1; busy_first = 1'b0;
    paddr = addr; pdata = data;
    for (int k = 1; k <= exp_done + 3; k++) begin
      @(negedge clk);
      if (k == 1) busy_first = busy;
      if (hold_start && k == 20) begin
        cfg  = 64'hFFEE_DDCC_BBAA_9988;
        mask = 8'hFF;
      end
      if (hold_start && k == exp_done) start = 1'b0;
      if (wr_en && !prev_wr && nrise < 8) begin
        rise_at[nrise] = k; ad[nrise] = addr; dt[nrise] = data; nrise++;
      end
      if (wr_en) high_cnt++;
      if (!wr_en && prev_wr) since_fall = 1;
      else if (!wr_en) since_fall++;
      if ((wr_en || since_fall <= 4) && (addr !== paddr || data !== pdata)) viol++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
        if (!busy) viol++;
      end
      if (done_at > 0 && k == done_at + 1) busy_after = busy;
      prev_wr = wr_en; paddr = addr; pdata = data;
    end

    check({tag, " busy_t1"}, busy_first, 1'b1);
    check({tag, " nrise"}, nrise, n_exp);
    for (int i = 0; i < nrise && i < n_exp; i++) begin
      check($sformatf("%s rise%0d_cyc", tag, i), rise_at[i], 2 + 9 * i);
      check($sformatf("%s rise%0d_addr", tag, i), ad[i], exp_addr[i]);
      check($sformatf("%s rise%0d_data", tag, i), dt[i], c[63-8*exp_addr[i] -: 8]);
    end
    check({tag, " high_cycles"}, high_cnt, 4 * n_exp);
    check({tag, " done_cyc"}, done_at, exp_done);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " busy_after_done"}, busy_after, 1'b0);
    check({tag, " stability"}, viol, 0);
  endtask

  initial begin
    int   dpulse, rb, hb, db;
    rst = 1'b1; start = 1'b0; cfg = '0; mask = '0;
    rst_b = 1'b1; start_b = 1'b0; cfg_b = '0; mask_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outs", {data, addr, wr_en, busy, done}, '0);
    check("reset outs b", {data_b, addr_b, wr_en_b, busy_b, done_b}, '0);
    rst = 1'b0; rst_b = 1'b0;

    xfer("full", 64'h0123_4567_89AB_CDEF, 8'hFF, 73, 1'b0);
    xfer("m85", 64'h1122_3344_5566_7788, 8'b1000_0101, 28, 1'b0);
    xfer("m00", 64'hDEAD_BEEF_0000_1111, 8'h00, 2, 1'b0);
    xfer("hold", 64'h0F1E_2D3C_4B5A_6978, 8'h5A, 37, 1'b1);
    repeat (3) @(negedge clk);
    check("hold idle after", busy, 1'b0);

    // reset during the addr 3 strobe (rise at cycle 29)
    @(negedge clk);
    cfg = 64'h0123_4567_89AB_CDEF; mask = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(negedge clk);
    check("pre-reset strobe", {wr_en, addr}, {1'b1, 3'd3});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post-reset", {wr_en, busy, done}, 3'b000);
    dpulse = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done || busy || wr_en) dpulse++;
    end
    check("reset quiet", dpulse, 0);
    xfer("after_rst", 64'h0123_4567_89AB_CDEF, 8'hFF, 73, 1'b0);

    // second instance: S=2 H=3 G=3, single register
    @(negedge clk);
    cfg_b = 64'hA5FF_FFFF_FFFF_FFFF; mask_b = 8'h01; start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    rb = -1; hb = 0; db = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (wr_en_b) begin
        hb++;
        if (rb < 0) rb = k;
      end
      if (done_b && db < 0) db = k;
    end
    check("b rise_cyc", rb, 3);
    check("b high", hb, 3);
    check("b done", db, 9);
    check("b data", {addr_b, data_b}, {3'd0, 8'hA5});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
